// File: rtl/pipe_pkg.sv
// Shared control-pipe types: per-stage control word, bubble constant, halt FSM states.
package pipe_pkg;

    localparam int REG_ADDR_W = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        logic      reg_wren;
        logic      mem_to_reg;
        logic      mem_wr;
        logic      alu_src;
        logic      branch;
        logic      halt;
        reg_addr_t dst;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } halt_state_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-side control bus plus the per-stage control outputs and IF/ID hazard controls.
interface ctrl_pipe_if;
    import pipe_pkg::*;

    logic      id_valid;
    logic      id_reg_wren;
    logic      id_mem_to_reg;
    logic      id_mem_wr;
    logic      id_alu_src;
    logic      id_dst_reg_sel;
    logic      id_branch;
    logic      id_halt;
    reg_addr_t id_rs;
    reg_addr_t id_rt;
    reg_addr_t id_rd;
    logic      id_uses_rt;
    logic      ex_branch_taken;
    logic      mem_stall;

    logic      stall_if_id;
    logic      flush_if_id;
    logic      ex_valid, ex_reg_wren, ex_mem_to_reg, ex_mem_wr, ex_alu_src, ex_branch;
    reg_addr_t ex_dst;
    logic      mem_valid, mem_reg_wren, mem_mem_to_reg, mem_mem_wr;
    reg_addr_t mem_dst;
    logic      wb_valid, wb_reg_wren, wb_mem_to_reg;
    reg_addr_t wb_dst;
    logic      halted;

    modport master (
        output id_valid, id_reg_wren, id_mem_to_reg, id_mem_wr, id_alu_src, id_dst_reg_sel,
               id_branch, id_halt, id_rs, id_rt, id_rd, id_uses_rt, ex_branch_taken, mem_stall,
        input  stall_if_id, flush_if_id,
               ex_valid, ex_reg_wren, ex_mem_to_reg, ex_mem_wr, ex_alu_src, ex_branch, ex_dst,
               mem_valid, mem_reg_wren, mem_mem_to_reg, mem_mem_wr, mem_dst,
               wb_valid, wb_reg_wren, wb_mem_to_reg, wb_dst, halted
    );

    modport slave (
        input  id_valid, id_reg_wren, id_mem_to_reg, id_mem_wr, id_alu_src, id_dst_reg_sel,
               id_branch, id_halt, id_rs, id_rt, id_rd, id_uses_rt, ex_branch_taken, mem_stall,
        output stall_if_id, flush_if_id,
               ex_valid, ex_reg_wren, ex_mem_to_reg, ex_mem_wr, ex_alu_src, ex_branch, ex_dst,
               mem_valid, mem_reg_wren, mem_mem_to_reg, mem_mem_wr, mem_dst,
               wb_valid, wb_reg_wren, wb_mem_to_reg, wb_dst, halted
    );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register: loads d on en, loads a bubble on en&clr.
// Latency: 1 cycle.
// Backpressure: en=0 holds the current contents.
module ctrl_stage_reg
    import pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  clr,
    input  ctrl_t d,
    output ctrl_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= clr ? BUBBLE : d;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decode control through EX/MEM/WB and raises IF/ID stall/flush for hazards and HLT.
// Latency: one cycle per stage (ID accepted at edge N -> EX after N, MEM N+1, WB N+2).
// Backpressure: mem_stall freezes EX/MEM/WB and holds IF/ID; load-use and HLT drain hold IF/ID only.
module ctrl_pipe
    import pipe_pkg::*;
#(
    parameter int NUM_FLUSH = 1
) (
    input logic         clk,
    input logic         rst,
    ctrl_pipe_if.slave  bus
);

    if (NUM_FLUSH != 1) begin : g_bad_num_flush
        $error("ctrl_pipe: only NUM_FLUSH=1 is supported");
    end

    ctrl_t       id_ctrl, ex_q, mem_q, wb_q;
    halt_state_t state;
    logic        advance, drain, load_use, br_flush, id_squash;
    logic        unused_bits;

    assign advance = !bus.mem_stall;
    assign drain   = (state != ST_RUN);

    // R0 never carries a load result, so it cannot cause a load-use stall.
    assign load_use = bus.id_valid && ex_q.valid && ex_q.mem_to_reg && (ex_q.dst != '0)
                   && ((ex_q.dst == bus.id_rs) || (bus.id_uses_rt && (ex_q.dst == bus.id_rt)));

    // A flush raised during a memory stall is deferred until the pipe moves again.
    assign br_flush  = advance && bus.ex_branch_taken && ex_q.valid;
    assign id_squash = br_flush || drain || load_use || !bus.id_valid;

    assign id_ctrl = '{
        valid:      1'b1,
        reg_wren:   bus.id_reg_wren,
        mem_to_reg: bus.id_mem_to_reg,
        mem_wr:     bus.id_mem_wr,
        alu_src:    bus.id_alu_src,
        branch:     bus.id_branch,
        halt:       bus.id_halt,
        dst:        bus.id_dst_reg_sel ? bus.id_rd : bus.id_rt
    };

    ctrl_stage_reg u_id_ex  (.clk(clk), .rst(rst), .en(advance), .clr(id_squash), .d(id_ctrl), .q(ex_q));
    ctrl_stage_reg u_ex_mem (.clk(clk), .rst(rst), .en(advance), .clr(1'b0),      .d(ex_q),    .q(mem_q));
    ctrl_stage_reg u_mem_wb (.clk(clk), .rst(rst), .en(advance), .clr(1'b0),      .d(mem_q),   .q(wb_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (advance) begin
            case (state)
                ST_RUN:   if (!id_squash && bus.id_halt) state <= ST_DRAIN;
                ST_DRAIN: if (wb_q.valid && wb_q.halt)   state <= ST_HALTED;
                default:  state <= state;
            endcase
        end
    end

    assign bus.stall_if_id = bus.mem_stall || (!br_flush && (drain || load_use));
    assign bus.flush_if_id = br_flush;
    assign bus.halted      = (state == ST_HALTED);

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_reg_wren   = ex_q.valid & ex_q.reg_wren;
    assign bus.ex_mem_to_reg = ex_q.valid & ex_q.mem_to_reg;
    assign bus.ex_mem_wr     = ex_q.valid & ex_q.mem_wr;
    assign bus.ex_alu_src    = ex_q.valid & ex_q.alu_src;
    assign bus.ex_branch     = ex_q.valid & ex_q.branch;
    assign bus.ex_dst        = ex_q.valid ? ex_q.dst : '0;

    assign bus.mem_valid      = mem_q.valid;
    assign bus.mem_reg_wren   = mem_q.valid & mem_q.reg_wren;
    assign bus.mem_mem_to_reg = mem_q.valid & mem_q.mem_to_reg;
    assign bus.mem_mem_wr     = mem_q.valid & mem_q.mem_wr;
    assign bus.mem_dst        = mem_q.valid ? mem_q.dst : '0;

    assign bus.wb_valid      = wb_q.valid;
    assign bus.wb_reg_wren   = wb_q.valid & wb_q.reg_wren;
    assign bus.wb_mem_to_reg = wb_q.valid & wb_q.mem_to_reg;
    assign bus.wb_dst        = wb_q.valid ? wb_q.dst : '0;

    assign unused_bits = ^{wb_q.mem_wr, wb_q.alu_src, wb_q.branch};

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboarded bench: directed hazard sequences then random traffic against an instruction-level model.
module tb_ctrl_pipe;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_pipe_if bus ();
    ctrl_pipe #(.NUM_FLUSH(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int K_NOP = 0, K_ADD = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_HLT = 5;

    typedef struct {
        bit valid, reg_wren, mem_to_reg, mem_wr, alu_src, dst_sel, branch, halt, uses_rt;
        int rs, rt, rd;
    } dec_t;

    typedef struct {
        bit valid, reg_wren, mem_to_reg, mem_wr, alu_src, branch, halt;
        int dst;
    } instr_t;

    typedef struct {
        bit stall, flush, halted;
        logic [9:0] ex;
        logic [7:0] mem;
        logic [6:0] wb;
        int cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    instr_t m_ex, m_mem, m_wb;
    bit     m_drain, m_halted;

    function automatic dec_t mk(int kind, int rs, int rt, int rd);
        dec_t d = '{default: 0};
        d.rs = rs; d.rt = rt; d.rd = rd;
        d.valid = (kind != K_NOP);
        case (kind)
            K_ADD: begin d.reg_wren = 1; d.dst_sel = 1; d.uses_rt = 1; end
            K_LW:  begin d.reg_wren = 1; d.mem_to_reg = 1; d.alu_src = 1; end
            K_SW:  begin d.mem_wr = 1; d.alu_src = 1; d.uses_rt = 1; end
            K_BEQ: begin d.branch = 1; d.uses_rt = 1; end
            K_HLT: d.halt = 1;
            default: ;
        endcase
        return d;
    endfunction

    function automatic dec_t rand_instr();
        dec_t d;
        int k = $urandom_range(0, 29);
        int kind = (k == 0) ? K_HLT : (k < 9) ? K_LW : (k < 13) ? K_SW : (k < 17) ? K_BEQ : K_ADD;
        d = mk(kind, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) begin
            // invalid slot carrying junk control bits: none of it may leak out
            d.valid = 0; d.reg_wren = 1'($urandom); d.mem_to_reg = 1'($urandom);
            d.mem_wr = 1'($urandom); d.halt = 1'($urandom); d.branch = 1'($urandom);
        end
        return d;
    endfunction

    function automatic logic [9:0] pk_ex(instr_t m);
        return {m.valid, m.reg_wren, m.mem_to_reg, m.mem_wr, m.alu_src, m.branch, 4'(m.dst)};
    endfunction

    function automatic logic [7:0] pk_mem(instr_t m);
        return {m.valid, m.reg_wren, m.mem_to_reg, m.mem_wr, 4'(m.dst)};
    endfunction

    function automatic logic [6:0] pk_wb(instr_t m);
        return {m.valid, m.reg_wren, m.mem_to_reg, 4'(m.dst)};
    endfunction

    // One clock of stimulus: expected outputs for this cycle go to the scoreboard,
    // then the model retires/advances instructions as the edge dictates.
    task automatic cycle(input dec_t d, input bit br, input bit ms, input bit r, output bit stalled);
        exp_t   e;
        bit     hz, fl;
        instr_t ent = '{default: 0};
        bus.id_valid = d.valid;         bus.id_reg_wren = d.reg_wren;
        bus.id_mem_to_reg = d.mem_to_reg; bus.id_mem_wr = d.mem_wr;
        bus.id_alu_src = d.alu_src;     bus.id_dst_reg_sel = d.dst_sel;
        bus.id_branch = d.branch;       bus.id_halt = d.halt;
        bus.id_rs = 4'(d.rs); bus.id_rt = 4'(d.rt); bus.id_rd = 4'(d.rd);
        bus.id_uses_rt = d.uses_rt;     bus.ex_branch_taken = br;
        bus.mem_stall = ms;             rst = r;

        hz = d.valid && m_ex.valid && m_ex.mem_to_reg && m_ex.dst != 0
             && (m_ex.dst == d.rs || (d.uses_rt && m_ex.dst == d.rt));
        fl = br && m_ex.valid && !ms;
        e.stall  = ms || (!fl && (m_drain || hz));
        e.flush  = fl;
        e.halted = m_halted;
        e.ex = pk_ex(m_ex); e.mem = pk_mem(m_mem); e.wb = pk_wb(m_wb);
        e.cyc = cyc;
        sb.push_back(e);
        stalled = e.stall;

        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
            m_drain = 0; m_halted = 0;
        end else if (!ms) begin
            if (m_wb.valid && m_wb.halt) m_halted = 1;
            m_wb  = m_mem;
            m_mem = m_ex;
            if (d.valid && !fl && !m_drain && !hz) begin
                ent.valid = 1; ent.reg_wren = d.reg_wren; ent.mem_to_reg = d.mem_to_reg;
                ent.mem_wr = d.mem_wr; ent.alu_src = d.alu_src; ent.branch = d.branch;
                ent.halt = d.halt; ent.dst = d.dst_sel ? d.rd : d.rt;
                m_ex = ent;
                if (d.halt) m_drain = 1;
            end else begin
                m_ex = '{default: 0};
            end
        end
    endtask

    task automatic check(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("stall_if_id", e.cyc, 16'(bus.stall_if_id), 16'(e.stall));
                check("flush_if_id", e.cyc, 16'(bus.flush_if_id), 16'(e.flush));
                check("halted", e.cyc, 16'(bus.halted), 16'(e.halted));
                check("ex_stage", e.cyc, 16'({bus.ex_valid, bus.ex_reg_wren, bus.ex_mem_to_reg,
                      bus.ex_mem_wr, bus.ex_alu_src, bus.ex_branch, bus.ex_dst}), 16'(e.ex));
                check("mem_stage", e.cyc, 16'({bus.mem_valid, bus.mem_reg_wren, bus.mem_mem_to_reg,
                      bus.mem_mem_wr, bus.mem_dst}), 16'(e.mem));
                check("wb_stage", e.cyc, 16'({bus.wb_valid, bus.wb_reg_wren, bus.wb_mem_to_reg,
                      bus.wb_dst}), 16'(e.wb));
            end
        end
    end

    initial begin : stimulus
        dec_t nop, cur;
        bit   st;
        m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
        m_drain = 0; m_halted = 0;
        nop = mk(K_NOP, 0, 0, 0);
        bus.id_valid = 0; bus.id_reg_wren = 0; bus.id_mem_to_reg = 0; bus.id_mem_wr = 0;
        bus.id_alu_src = 0; bus.id_dst_reg_sel = 0; bus.id_branch = 0; bus.id_halt = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_uses_rt = 0;
        bus.ex_branch_taken = 0; bus.mem_stall = 0;
        rst = 1;
        @(posedge clk);
        #1;
        cycle(nop, 0, 0, 1, st);
        cycle(nop, 0, 0, 1, st);

        // straight ADD r5
        cycle(mk(K_ADD, 1, 2, 5), 0, 0, 0, st);
        repeat (4) cycle(nop, 0, 0, 0, st);

        // load-use on r3 (ADD re-presented while stalled), then the same pattern on r0
        cycle(mk(K_LW, 1, 3, 0), 0, 0, 0, st);
        cycle(mk(K_ADD, 3, 2, 6), 0, 0, 0, st);
        cycle(mk(K_ADD, 3, 2, 6), 0, 0, 0, st);
        repeat (3) cycle(nop, 0, 0, 0, st);
        cycle(mk(K_LW, 1, 0, 0), 0, 0, 0, st);
        cycle(mk(K_ADD, 0, 2, 7), 0, 0, 0, st);
        repeat (3) cycle(nop, 0, 0, 0, st);

        // taken branch squashes ID; then flush coinciding with a load-use
        cycle(mk(K_BEQ, 1, 2, 0), 0, 0, 0, st);
        cycle(mk(K_ADD, 1, 2, 7), 1, 0, 0, st);
        cycle(mk(K_LW, 1, 4, 0), 0, 0, 0, st);
        cycle(mk(K_ADD, 4, 2, 8), 1, 0, 0, st);
        repeat (3) cycle(nop, 0, 0, 0, st);

        // memory stall for three cycles with a load in MEM
        cycle(mk(K_LW, 2, 9, 0), 0, 0, 0, st);
        cycle(mk(K_ADD, 1, 1, 10), 0, 0, 0, st);
        repeat (3) cycle(mk(K_ADD, 2, 2, 11), 0, 1, 0, st);
        repeat (4) cycle(mk(K_ADD, 2, 2, 11), 0, 0, 0, st);

        // HLT drains, then reset with the pipe full
        cycle(mk(K_HLT, 0, 0, 0), 0, 0, 0, st);
        repeat (6) cycle(mk(K_ADD, 1, 2, 3), 0, 0, 0, st);
        repeat (3) cycle(mk(K_ADD, 1, 2, 12), 0, 0, 0, st);
        cycle(nop, 0, 0, 1, st);
        cycle(nop, 0, 0, 0, st);

        // HLT squashed by an older taken branch
        cycle(mk(K_BEQ, 1, 2, 0), 0, 0, 0, st);
        cycle(mk(K_HLT, 0, 0, 0), 1, 0, 0, st);
        repeat (5) cycle(nop, 0, 0, 0, st);

        cur = rand_instr();
        for (int i = 0; i < 1500; i++) begin
            bit br = ($urandom_range(0, 7) == 0);
            bit ms = ($urandom_range(0, 5) == 0);
            bit r  = ($urandom_range(0, 59) == 0);
            cycle(cur, br, ms, r, st);
            if (r || !st) cur = rand_instr();
        end
        cycle(nop, 0, 0, 0, st);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the decode-stage control bus: carries control_unit outputs from ID through EX, MEM and WB.
- Also carries per-stage valid bits and the resolved destination register.
- Generates IF/ID stall and flush for load-use hazards, taken branches, memory stalls and HLT drain.
- Sits between the decode stage and the EX/MEM/WB datapath registers; owns no datapath values.

Parameters:
- REG_ADDR_W, 4, register index width (16 registers, R0 reads zero)
- NUM_FLUSH, 1, number of younger slots squashed on a taken branch (only 1 supported)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_reg_wren, id_mem_to_reg, id_mem_wr, id_alu_src, id_dst_reg_sel, id_branch  in  1 each  control_unit outputs
- id_halt  in  1  ID instruction is HLT
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  source/destination fields
- id_uses_rt  in  1  instruction reads rt as a source
- ex_branch_taken  in  1  EX resolved a taken branch this cycle
- mem_stall  in  1  data memory not ready; freeze pipeline
- stall_if_id  out  1  hold PC and IF/ID register
- flush_if_id  out  1  replace IF/ID contents with bubble
- ex_valid, ex_reg_wren, ex_mem_to_reg, ex_mem_wr, ex_alu_src, ex_branch  out  1 each
- ex_dst  out  REG_ADDR_W
- mem_valid, mem_reg_wren, mem_mem_to_reg, mem_mem_wr  out  1 each
- mem_dst  out  REG_ADDR_W
- wb_valid, wb_reg_wren, wb_mem_to_reg  out  1 each
- wb_dst  out  REG_ADDR_W
- halted  out  1  sticky: HLT retired

Behaviour:
- Reset: synchronous on rst=1 at posedge. All stage valids, control bits, dst fields, halted, stall_if_id and flush_if_id are 0.
- Destination: id_dst = id_dst_reg_sel ? id_rd : id_rt, resolved on ID->EX entry.
- Gated outputs: all stage control outputs are ANDed with their stage valid. A bubble drives every control bit to 0 and dst to 0.
- Latency: one cycle per stage. An ID instruction accepted at edge N appears in EX after N, MEM after N+1, WB after N+2.
- Load-use hazard, detected combinationally when all hold:
  - ex_valid & ex_mem_to_reg & ex_dst != 0
  - ex_dst == id_rs, or (id_uses_rt & ex_dst == id_rt)
  - id_valid
  - Response: stall_if_id=1 and a bubble enters EX at the next edge; MEM/WB advance normally. Exactly one stall cycle per hazard.
- Taken branch: ex_branch_taken & ex_valid gives flush_if_id=1, and the ID instruction is squashed (bubble into EX). No stall.
- Memory stall: mem_stall=1 freezes EX, MEM and WB registers and sets stall_if_id=1. flush_if_id is suppressed and takes effect on the first non-stalled cycle.
- Priority: rst > mem_stall > branch flush > load-use. Branch and load-use in the same cycle: flush wins, stall_if_id=0.
- HLT:
  - A halt accepted into EX sets an internal halting flag; afterwards stall_if_id=1 permanently and bubbles enter EX.
  - halt_pending is squashed if the halt is flushed by an older taken branch.
  - halted asserts the cycle after the halt instruction leaves WB and stays set until rst.
- Halt path bits: id_halt travels with the instruction down the pipe (ex_halt/mem_halt/wb_halt internal). reg_wren is already 0 for HLT.
- R0: writes to dst 0 never create a hazard.
- Reset mid-operation: all in-flight instructions are discarded and there are no outputs in the following cycle.

Decomposition:
- Shared package (pipe_pkg): REG_ADDR_W; a stage-control struct {valid, reg_wren, mem_to_reg, mem_wr, alu_src, branch, halt, dst}; a BUBBLE constant (all zero).
- Sub-module ctrl_stage_reg: one stage register with en (advance), clr (bubble) and sync rst. Instantiated three times (ID/EX, EX/MEM, MEM/WB).

Test Plan:
- Straight ADD (reg_wren=1, dst_reg_sel=1, rd=5) at cycle 0 -> ex_dst=5 at cycle 1, mem at 2, wb_reg_wren=1, wb_dst=5 at 3. No stall/flush.
- LW rt=3 followed by ADD rs=3 -> stall_if_id=1 for exactly one cycle, EX bubble (ex_valid=0). ADD reaches WB two cycles after LW. Repeat with rt=0 -> no stall.
- ex_branch_taken=1 with valid ID instr -> flush_if_id=1 that cycle, next ex_valid=0. Same cycle with load-use condition -> stall_if_id=0.
- mem_stall held 3 cycles with LW in MEM -> mem/wb outputs unchanged for 3 cycles and stall_if_id=1; resume advances by one stage per cycle.
- HLT at cycle 0 followed by ADDs -> stall_if_id=1 from cycle 1 onward, ADDs never enter EX, halted=1 at cycle 4 and held. HLT squashed by branch -> halted stays 0.
- rst asserted mid-stream with all stages valid -> next cycle all valids 0, halted=0, stall/flush=0.
